// File: rtl/roi_crop_ctrl_pkg.sv
// Shared types and constants for the ROI crop controller and its stream counters.
package roi_crop_ctrl_pkg;

  localparam int unsigned COORD_W            = 9;
  localparam int unsigned IMG_W_DEF          = 320;
  localparam int unsigned IMG_H_DEF          = 240;
  localparam int unsigned TIMEOUT_FRAMES_DEF = 4;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQUEST   = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_WAIT_GAP  = 3'd3,
    ST_ARMED     = 3'd4,
    ST_CROP      = 3'd5
  } state_e;

  typedef struct packed {
    coord_t top;
    coord_t bot;
    coord_t left;
    coord_t right;
  } roi_bounds_t;

  // The ROI block may leave horizontal bounds at zero; treat that as full width.
  function automatic roi_bounds_t apply_full_width(input roi_bounds_t b,
                                                   input int unsigned img_w);
    roi_bounds_t r;
    r = b;
    if ((b.left == '0) && (b.right == '0)) begin
      r.right = COORD_W'(img_w - 1);
    end
    return r;
  endfunction

  function automatic logic bounds_valid(input roi_bounds_t b,
                                        input int unsigned img_w,
                                        input int unsigned img_h);
    return (b.top <= b.bot) && (b.left <= b.right) &&
           (32'(b.bot) < img_h) && (32'(b.right) < img_w);
  endfunction

endpackage

// File: rtl/roi_pixel_counter.sv
// DVAL/FVAL edge detection plus saturating column/line counters for a pixel stream.
module roi_pixel_counter
  import roi_crop_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   dval_i,
  input  logic   fval_i,
  output logic   fval_rise_c,
  output logic   fval_fall_c,
  output logic   dval_fall_c,
  output logic   pix_ok_c,
  output coord_t col_o,
  output coord_t line_o
);

  localparam coord_t COL_MAX  = COORD_W'(IMG_W - 1);
  localparam coord_t LINE_MAX = COORD_W'(IMG_H - 1);

  logic   fval_q;
  logic   dval_q;
  logic   col_full_q;
  logic   col_full_d;
  logic   line_full_q;
  logic   line_full_d;
  coord_t col_q;
  coord_t col_d;
  coord_t line_q;
  coord_t line_d;

  assign fval_rise_c = fval_i & ~fval_q;
  assign fval_fall_c = ~fval_i & fval_q;
  assign dval_fall_c = ~dval_i & dval_q;
  // The frame-start cycle only resynchronises; pixels past the last column/line are dropped.
  assign pix_ok_c    = dval_i & ~fval_rise_c & ~col_full_q & ~line_full_q;

  assign col_o  = col_q;
  assign line_o = line_q;

  always_comb begin
    col_d       = col_q;
    line_d      = line_q;
    col_full_d  = col_full_q;
    line_full_d = line_full_q;
    if (fval_rise_c) begin
      col_d       = '0;
      line_d      = '0;
      col_full_d  = 1'b0;
      line_full_d = 1'b0;
    end else if (dval_fall_c) begin
      col_d      = '0;
      col_full_d = 1'b0;
      if (line_q == LINE_MAX) begin
        line_full_d = 1'b1;
      end else begin
        line_d = line_q + COORD_W'(1);
      end
    end else if (pix_ok_c) begin
      if (col_q == COL_MAX) begin
        col_full_d = 1'b1;
      end else begin
        col_d = col_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fval_q      <= 1'b0;
      dval_q      <= 1'b0;
      col_q       <= '0;
      line_q      <= '0;
      col_full_q  <= 1'b0;
      line_full_q <= 1'b0;
    end else begin
      fval_q      <= fval_i;
      dval_q      <= dval_i;
      col_q       <= col_d;
      line_q      <= line_d;
      col_full_q  <= col_full_d;
      line_full_q <= line_full_d;
    end
  end

endmodule

// File: rtl/roi_crop_ctrl.sv
// ROI handshake initiator: requests bounds, latches/validates them, then crops the next whole frame.
module roi_crop_ctrl
  import roi_crop_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W          = IMG_W_DEF,
  parameter int unsigned IMG_H          = IMG_H_DEF,
  parameter int unsigned TIMEOUT_FRAMES = TIMEOUT_FRAMES_DEF
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iTrigger,
  output logic               oROIStart,
  input  logic               iROIDone,
  input  logic [COORD_W-1:0] iTopBound,
  input  logic [COORD_W-1:0] iBotBound,
  input  logic [COORD_W-1:0] iLeftBound,
  input  logic [COORD_W-1:0] iRightBound,
  input  logic               iDATA,
  input  logic               iDVAL,
  input  logic               iFVAL,
  output logic               oPixel,
  output logic               oPixelValid,
  output logic [COORD_W-1:0] oRow,
  output logic [COORD_W-1:0] oCol,
  output logic [COORD_W-1:0] oROIWidth,
  output logic [COORD_W-1:0] oROIHeight,
  output logic               oBusy,
  output logic               oFrameDone,
  output logic               oError
);

  localparam int unsigned FRM_W = $clog2(TIMEOUT_FRAMES + 1);

  state_e      state_q;
  state_e      state_d;
  logic        done_q;
  roi_bounds_t bounds_q;
  roi_bounds_t bounds_d;
  coord_t      width_q;
  coord_t      width_d;
  coord_t      height_q;
  coord_t      height_d;
  logic [FRM_W-1:0] frames_q;
  logic [FRM_W-1:0] frames_d;
  logic        start_q;
  logic        start_d;
  logic        busy_q;
  logic        busy_d;
  logic        error_q;
  logic        error_d;
  logic        frame_done_q;
  logic        frame_done_d;
  logic        pix_q;
  logic        pix_d;
  logic        pix_valid_q;
  logic        pix_valid_d;
  coord_t      row_q;
  coord_t      row_d;
  coord_t      col_out_q;
  coord_t      col_out_d;

  logic        fval_rise_c;
  logic        fval_fall_c;
  logic        dval_fall_c;
  logic        pix_ok_c;
  logic        done_rise_c;
  logic        inside_c;
  logic        last_line_c;
  coord_t      col_cnt;
  coord_t      line_cnt;
  roi_bounds_t new_bounds_c;

  roi_pixel_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pixel_counter (
    .clk         (iCLK),
    .rst_n       (iRST),
    .dval_i      (iDVAL),
    .fval_i      (iFVAL),
    .fval_rise_c (fval_rise_c),
    .fval_fall_c (fval_fall_c),
    .dval_fall_c (dval_fall_c),
    .pix_ok_c    (pix_ok_c),
    .col_o       (col_cnt),
    .line_o      (line_cnt)
  );

  // Only a fresh done edge counts; a level left high by an earlier run is ignored.
  assign done_rise_c  = iROIDone & ~done_q;
  assign new_bounds_c = apply_full_width({iTopBound, iBotBound, iLeftBound, iRightBound}, IMG_W);
  assign inside_c     = (line_cnt >= bounds_q.top)  && (line_cnt <= bounds_q.bot) &&
                        (col_cnt  >= bounds_q.left) && (col_cnt  <= bounds_q.right);
  assign last_line_c  = dval_fall_c && (line_cnt >= bounds_q.bot);

  always_comb begin
    state_d      = state_q;
    bounds_d     = bounds_q;
    width_d      = width_q;
    height_d     = height_q;
    frames_d     = frames_q;
    error_d      = error_q;
    frame_done_d = 1'b0;
    pix_valid_d  = 1'b0;
    pix_d        = pix_q;
    row_d        = row_q;
    col_out_d    = col_out_q;

    case (state_q)
      ST_IDLE: begin
        if (iTrigger) begin
          state_d = ST_REQUEST;
          error_d = 1'b0;
        end
      end
      ST_REQUEST: begin
        frames_d = '0;
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (done_rise_c) begin
          bounds_d = new_bounds_c;
          width_d  = new_bounds_c.right - new_bounds_c.left + COORD_W'(1);
          height_d = new_bounds_c.bot - new_bounds_c.top + COORD_W'(1);
          if (bounds_valid(new_bounds_c, IMG_W, IMG_H)) begin
            state_d = ST_WAIT_GAP;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (fval_rise_c) begin
          if (frames_q == FRM_W'(TIMEOUT_FRAMES - 1)) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frames_d = frames_q + FRM_W'(1);
          end
        end
      end
      ST_WAIT_GAP: begin
        if (!iFVAL) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (fval_rise_c) begin
          state_d = ST_CROP;
        end
      end
      ST_CROP: begin
        if (pix_ok_c && inside_c) begin
          pix_valid_d = 1'b1;
          pix_d       = iDATA;
          row_d       = line_cnt - bounds_q.top;
          col_out_d   = col_cnt - bounds_q.left;
        end
        // A truncated frame or passing the bottom bound both close the crop cleanly.
        if (fval_fall_c || last_line_c) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    start_d = (state_d == ST_REQUEST);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      bounds_q     <= '0;
      width_q      <= '0;
      height_q     <= '0;
      frames_q     <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      frame_done_q <= 1'b0;
      pix_q        <= 1'b0;
      pix_valid_q  <= 1'b0;
      row_q        <= '0;
      col_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= iROIDone;
      bounds_q     <= bounds_d;
      width_q      <= width_d;
      height_q     <= height_d;
      frames_q     <= frames_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      frame_done_q <= frame_done_d;
      pix_q        <= pix_d;
      pix_valid_q  <= pix_valid_d;
      row_q        <= row_d;
      col_out_q    <= col_out_d;
    end
  end

  assign oROIStart   = start_q;
  assign oBusy       = busy_q;
  assign oError      = error_q;
  assign oFrameDone  = frame_done_q;
  assign oPixel      = pix_q;
  assign oPixelValid = pix_valid_q;
  assign oRow        = row_q;
  assign oCol        = col_out_q;
  assign oROIWidth   = width_q;
  assign oROIHeight  = height_q;

endmodule

// File: tb/tb_roi_crop_ctrl.sv
// Directed + randomized bench for roi_crop_ctrl against a frame-level crop reference model.
module tb_roi_crop_ctrl;

  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int MAX_LL = 340;

  typedef struct packed {
    logic       pix;
    logic [8:0] row;
    logic [8:0] col;
  } pe_t;

  logic       iCLK;
  logic       iRST;
  logic       iTrigger;
  logic       oROIStart;
  logic       iROIDone;
  logic [8:0] iTopBound;
  logic [8:0] iBotBound;
  logic [8:0] iLeftBound;
  logic [8:0] iRightBound;
  logic       iDATA;
  logic       iDVAL;
  logic       iFVAL;
  logic       oPixel;
  logic       oPixelValid;
  logic [8:0] oRow;
  logic [8:0] oCol;
  logic [8:0] oROIWidth;
  logic [8:0] oROIHeight;
  logic       oBusy;
  logic       oFrameDone;
  logic       oError;

  int  vectors;
  int  miscompares;
  int  fd_cnt;
  pe_t obs_q[$];
  pe_t exp_q[$];
  logic frame_mem [0:IMG_H-1][0:MAX_LL-1];

  roi_crop_ctrl dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iTrigger    (iTrigger),
    .oROIStart   (oROIStart),
    .iROIDone    (iROIDone),
    .iTopBound   (iTopBound),
    .iBotBound   (iBotBound),
    .iLeftBound  (iLeftBound),
    .iRightBound (iRightBound),
    .iDATA       (iDATA),
    .iDVAL       (iDVAL),
    .iFVAL       (iFVAL),
    .oPixel      (oPixel),
    .oPixelValid (oPixelValid),
    .oRow        (oRow),
    .oCol        (oCol),
    .oROIWidth   (oROIWidth),
    .oROIHeight  (oROIHeight),
    .oBusy       (oBusy),
    .oFrameDone  (oFrameDone),
    .oError      (oError)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Output monitor, sampled on the inactive edge.
  always @(negedge iCLK) begin
    if (iRST) begin
      if (oPixelValid) obs_q.push_back({oPixel, oRow, oCol});
      if (oFrameDone) fd_cnt++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Trigger from IDLE; leaves the DUT in WAIT_DONE.
  task automatic do_trigger();
    iTrigger = 1'b1;
    tick();
    iTrigger = 1'b0;
    @(negedge iCLK);
    chk("start_pulse", 32'(oROIStart), 32'd1);
    chk("busy_request", 32'(oBusy), 32'd1);
    chk("error_cleared", 32'(oError), 32'd0);
    tick();
    @(negedge iCLK);
    chk("start_one_cycle", 32'(oROIStart), 32'd0);
  endtask

  task automatic do_done(input int t, input int b, input int l, input int r);
    iROIDone = 1'b0;
    tick();
    iTopBound   = 9'(t);
    iBotBound   = 9'(b);
    iLeftBound  = 9'(l);
    iRightBound = 9'(r);
    iROIDone    = 1'b1;
    tick();
    @(negedge iCLK);
  endtask

  task automatic send_frame(input int nlines, input int linelen);
    logic d;
    iFVAL = 1'b1;
    repeat (2) tick();
    for (int ln = 0; ln < nlines; ln++) begin
      for (int c = 0; c < linelen; c++) begin
        d = 1'($urandom_range(0, 1));
        if (ln < IMG_H && c < MAX_LL) frame_mem[ln][c] = d;
        iDATA = d;
        iDVAL = 1'b1;
        tick();
      end
      iDVAL = 1'b0;
      iDATA = 1'b0;
      repeat (3) tick();
    end
    iFVAL = 1'b0;
    repeat (4) tick();
  endtask

  // Reference crop: every sent pixel within the ROI rectangle, in raster order.
  function automatic void build_exp(input int t, input int b, input int l, input int r,
                                    input int nlines, input int linelen);
    int re;
    re = (l == 0 && r == 0) ? IMG_W - 1 : r;
    exp_q.delete();
    for (int ln = t; ln <= b && ln < nlines && ln < IMG_H; ln++)
      for (int c = l; c <= re && c < linelen && c < IMG_W; c++)
        exp_q.push_back({frame_mem[ln][c], 9'(ln - t), 9'(c - l)});
  endfunction

  task automatic run_frame(input int t, input int b, input int l, input int r,
                           input int nlines, input int linelen);
    int n;
    obs_q.delete();
    fd_cnt = 0;
    repeat (2) tick();
    send_frame(nlines, linelen);
    build_exp(t, b, l, r, nlines, linelen);
    @(negedge iCLK);
    chk("pixel_count", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("pixel_entry", 32'(obs_q[i]), 32'(exp_q[i]));
    chk("frame_done_count", 32'(fd_cnt), 32'd1);
    chk("busy_after_frame", 32'(oBusy), 32'd0);
    chk("error_after_frame", 32'(oError), 32'd0);
  endtask

  initial begin
    int t, b, l, r, re, nl, ll;
    vectors = 0;
    miscompares = 0;
    fd_cnt = 0;
    iRST = 1'b0;
    iTrigger = 1'b0;
    iROIDone = 1'b0;
    iTopBound = '0;
    iBotBound = '0;
    iLeftBound = '0;
    iRightBound = '0;
    iDATA = 1'b0;
    iDVAL = 1'b0;
    iFVAL = 1'b0;

    // Reset state
    repeat (3) @(negedge iCLK);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_start", 32'(oROIStart), 32'd0);
    chk("rst_valid", 32'(oPixelValid), 32'd0);
    chk("rst_error", 32'(oError), 32'd0);
    chk("rst_width", 32'(oROIWidth), 32'd0);
    chk("rst_height", 32'(oROIHeight), 32'd0);
    chk("rst_fdone", 32'(oFrameDone), 32'd0);
    @(posedge iCLK);
    #1 iRST = 1'b1;
    repeat (2) tick();

    // Nominal 10x10 ROI
    do_trigger();
    do_done(50, 59, 100, 109);
    chk("nom_width", 32'(oROIWidth), 32'd10);
    chk("nom_height", 32'(oROIHeight), 32'd10);
    chk("nom_busy", 32'(oBusy), 32'd1);
    run_frame(50, 59, 100, 109, 60, IMG_W);

    // Stale done level must not latch
    iTopBound = 9'd5; iBotBound = 9'd6; iLeftBound = 9'd20; iRightBound = 9'd24;
    iROIDone = 1'b1;
    repeat (3) tick();
    do_trigger();
    repeat (5) tick();
    @(negedge iCLK);
    chk("stale_busy", 32'(oBusy), 32'd1);
    chk("stale_width_held", 32'(oROIWidth), 32'd10);
    do_done(2, 4, 30, 37);
    chk("stale_width", 32'(oROIWidth), 32'd8);
    chk("stale_height", 32'(oROIHeight), 32'd3);
    run_frame(2, 4, 30, 37, 5, 40);

    // Full-width fallback with over-long line (column saturation)
    do_trigger();
    do_done(0, 0, 0, 0);
    chk("fw_width", 32'(oROIWidth), 32'd320);
    chk("fw_height", 32'(oROIHeight), 32'd1);
    run_frame(0, 0, 0, 0, 2, 330);

    // Randomized ROIs, some truncated early
    for (int k = 0; k < 6; k++) begin
      t = $urandom_range(0, 6);
      b = t + $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) begin
        l = 0; r = 0;
      end else begin
        l = $urandom_range(0, 300);
        r = l + $urandom_range(0, 18);
      end
      re = (l == 0 && r == 0) ? IMG_W - 1 : r;
      nl = t + 1 + $urandom_range(0, b - t + 1);
      ll = re + 1 + $urandom_range(0, 3);
      do_trigger();
      do_done(t, b, l, r);
      chk("rnd_width", 32'(oROIWidth), 32'(re - l + 1));
      chk("rnd_height", 32'(oROIHeight), 32'(b - t + 1));
      run_frame(t, b, l, r, nl, ll);
    end

    // Invalid bounds
    do_trigger();
    do_done(100, 20, 5, 9);
    chk("inv_error", 32'(oError), 32'd1);
    chk("inv_busy", 32'(oBusy), 32'd0);
    obs_q.delete();
    fd_cnt = 0;
    send_frame(2, 20);
    chk("inv_no_pixels", 32'(obs_q.size()), 32'd0);
    chk("inv_no_fdone", 32'(fd_cnt), 32'd0);
    chk("inv_error_sticky", 32'(oError), 32'd1);
    iROIDone = 1'b0;
    tick();

    // Timeout: trigger clears error, then four frame starts without done
    do_trigger();
    for (int f = 0; f < 3; f++) begin
      iFVAL = 1'b1;
      repeat (2) tick();
      iFVAL = 1'b0;
      repeat (2) tick();
    end
    @(negedge iCLK);
    chk("to_busy_before", 32'(oBusy), 32'd1);
    chk("to_error_before", 32'(oError), 32'd0);
    iFVAL = 1'b1;
    tick();
    @(negedge iCLK);
    chk("to_error", 32'(oError), 32'd1);
    chk("to_busy", 32'(oBusy), 32'd0);
    iFVAL = 1'b0;
    repeat (3) tick();

    // Truncated frame: FVAL drops at line 55 with bot=59
    do_trigger();
    do_done(50, 59, 10, 29);
    run_frame(50, 59, 10, 29, 55, 40);

    // Reset in the middle of a crop
    do_trigger();
    do_done(0, 3, 0, 50);
    repeat (3) tick();
    iFVAL = 1'b1;
    repeat (2) tick();
    for (int c = 0; c < 10; c++) begin
      iDATA = 1'($urandom_range(0, 1));
      iDVAL = 1'b1;
      tick();
    end
    @(negedge iCLK);
    chk("mid_valid_before_rst", 32'(oPixelValid), 32'd1);
    iRST = 1'b0;
    #1;
    chk("mrst_valid", 32'(oPixelValid), 32'd0);
    chk("mrst_busy", 32'(oBusy), 32'd0);
    chk("mrst_row_col", 32'({oRow, oCol}), 32'd0);
    chk("mrst_width", 32'(oROIWidth), 32'd0);
    chk("mrst_misc", 32'({oPixel, oFrameDone, oError, oROIStart}), 32'd0);
    iDVAL = 1'b0;
    iFVAL = 1'b0;
    iROIDone = 1'b0;
    repeat (2) tick();
    iRST = 1'b1;
    repeat (3) tick();
    @(negedge iCLK);
    chk("post_rst_busy", 32'(oBusy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/roi_crop_ctrl.md
Name: roi_crop_ctrl

Overview:
- Initiator/consumer for the ROI bound-finder handshake. On a trigger it pulses the ROI start input and waits for done. It then latches top/bottom/left/right bounds.
- On the next complete frame it streams out only the binarized pixels inside the ROI, tagged with ROI-relative row/column, for the downstream digit-normalisation stage.

Parameters:
- IMG_W, 320, active pixels per line.
- IMG_H, 240, active lines per frame.
- TIMEOUT_FRAMES, 4, frame starts (iFVAL rising edges) allowed in WAIT_DONE before error.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  asynchronous active-low reset.
- iTrigger  in  1  request a new ROI capture; level-sampled, honoured only in IDLE.
- oROIStart  out  1  one-cycle start pulse to ROI block.
- iROIDone  in  1  ROI done level.
- iTopBound, iBotBound, iLeftBound, iRightBound  in  9 each  ROI bounds.
- iDATA  in  1  binarized pixel (1 = white).
- iDVAL  in  1  pixel valid.
- iFVAL  in  1  frame valid.
- oPixel  out  1  cropped pixel.
- oPixelValid  out  1  oPixel/oRow/oCol valid.
- oRow, oCol  out  9 each  ROI-relative coordinates.
- oROIWidth, oROIHeight  out  9 each  latched right-left+1, bot-top+1.
- oBusy  out  1  high in any state except IDLE.
- oFrameDone  out  1  one-cycle pulse at end of cropped frame.
- oError  out  1  sticky until next accepted trigger.

Behaviour:
- Reset: all outputs 0; state IDLE; counters and latched bounds 0.
- States:
  - IDLE: iTrigger=1 -> REQUEST; oError cleared on that transition.
  - REQUEST: oROIStart=1 for exactly this cycle -> WAIT_DONE.
  - WAIT_DONE:
    - Completion is a rising edge of iROIDone (registered done_q=0, iROIDone=1). A done level left high from a previous run is ignored.
    - On completion, latch bounds and validate them:
      - Valid -> WAIT_GAP.
      - Invalid -> oError=1, go to IDLE.
    - Frame counter increments on each iFVAL rising edge. Reaching TIMEOUT_FRAMES -> oError=1, go to IDLE.
  - WAIT_GAP: wait for iFVAL=0 so cropping starts on a whole frame -> ARMED.
  - ARMED: iFVAL rising -> CROP with col=0, line=0.
  - CROP:
    - Absolute col increments on each iDVAL=1 cycle.
    - End of line = iDVAL 1->0: col<=0, line<=line+1.
    - A pixel is inside when top<=line<=bot and left<=col<=right.
    - Inside pixels output registered, 1-cycle latency: oPixel=iDATA, oRow=line-top, oCol=col-left, oPixelValid=1.
    - iFVAL falling -> oFrameDone pulse (same cycle as state change) -> IDLE.
    - Early exit: line>bot seen at end of line -> pulse and IDLE, without waiting for iFVAL falling.
- Bound rules:
  - left==0 and right==0: full width, left=0, right=IMG_W-1. The ROI block may not yet drive horizontal bounds.
  - Invalid: top>bot, left>right, bot>=IMG_H, right>=IMG_W.
- Width/arithmetic:
  - Counters are 9-bit.
  - col saturates at IMG_W-1: extra DVAL cycles are ignored, no wrap.
  - Lines beyond IMG_H-1 are ignored.
- Simultaneous events:
  - iTrigger while busy: ignored.
  - Done edge and timeout in the same cycle: done wins.
- Truncated frame: iFVAL falling mid-line or before bot is reached still ends the crop with oFrameDone. No error.
- Reset mid-crop: immediate return to IDLE; oPixelValid low on the same edge.
- oBusy=1 in all states except IDLE.

Decomposition:
- Shared package: state encoding (6 states, 3-bit); IMG_W/IMG_H defaults; 9-bit coordinate width constant.
- Sub-module roi_pixel_counter: iDVAL/iFVAL edge detection plus col/line counters with saturation. Reused by other stream consumers.
- Top-level roi_crop_ctrl holds the FSM, bound latching/validation and the output register.

Test Plan:
- Nominal: trigger; ROI done edge with bounds top=50, bot=59, left=100, right=109 -> exactly 100 oPixelValid pulses, oRow/oCol 0..9, oROIWidth=oROIHeight=10, one oFrameDone, oError=0.
- Stale done: iROIDone held high before trigger -> no latch until done drops and re-rises; bounds come from the second edge.
- Full-width fallback: left=right=0, top=0, bot=0 -> 320 valid pulses, oCol 0..319, oRow=0.
- Invalid bounds: top=100, bot=20 -> oError=1, return to IDLE, no oPixelValid. Next trigger clears oError.
- Timeout: no done edge across 4 frame starts -> oError=1 on the 4th iFVAL rise, oBusy=0.
- Truncation/reset: iFVAL drops at line 55 with bot=59 -> oFrameDone pulse, no error. Separately, iRST low mid-crop -> all outputs 0 immediately.
